// File: rtl/assoc_cache.sv
// assoc_cache: set-associative write-back cache with true-LRU replacement and sequential invalidate-all.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module assoc_cache #(
   parameter int SETS       = 64,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4,
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [WORD_W-1:0]            req_wdata,
   output logic                         resp_valid,
   output logic [WORD_W-1:0]            resp_rdata,
   input  logic                         inv_all,
   output logic                         inv_busy,
   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic                         mem_req_write,
   output logic [ADDR_W-1:0]            mem_req_addr,
   output logic [LINE_WORDS*WORD_W-1:0] mem_wdata,
   input  logic                         mem_resp_valid,
   input  logic [LINE_WORDS*WORD_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]                  hit_count,
   output logic [31:0]                  miss_count
`endif
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int SET_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - OFF_W - SET_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;
   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND, INVALIDATE} state_t;

   state_t state, next;

   logic              r_write, r_hit;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata, r_rdata;
   logic [WAY_W-1:0]  r_way;
   logic [SET_W-1:0]  inv_set;

   logic              valid_q [SETS][WAYS];
   logic              dirty_q [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   line_t             data_q  [SETS][WAYS];

   logic [OFF_W-1:0]  r_off;
   logic [SET_W-1:0]  r_set;
   logic [TAG_W-1:0]  r_tag;
   logic              hit, inv_found, victim_dirty;
   logic [WAY_W-1:0]  hit_way, inv_way, lru_way, victim;
   line_t             fill_line;

   assign r_off = r_addr[OFF_W-1:0];
   assign r_set = r_addr[OFF_W +: SET_W];
   assign r_tag = r_addr[ADDR_W-1 -: TAG_W];

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[r_set][w] && tag_q[r_set][w] == r_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[r_set][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim       = inv_found ? inv_way : lru_way;
      victim_dirty = valid_q[r_set][victim] && dirty_q[r_set][victim];
   end

   always_comb begin
      fill_line = mem_rdata;
      if (r_write) fill_line[r_off] = r_wdata;
   end

   // Ages form a permutation of 0..WAYS-1, so the LRU way is the one holding WAYS-1.
   generate
      if (WAYS > 1) begin : g_lru
         logic [WAY_W-1:0] age_q [SETS][WAYS];

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               for (int unsigned s = 0; s < SETS; s++)
                  for (int unsigned w = 0; w < WAYS; w++)
                     age_q[s][w] <= WAY_W'(w);
            end else if (state == INVALIDATE) begin
               for (int unsigned w = 0; w < WAYS; w++)
                  age_q[inv_set][w] <= WAY_W'(w);
            end else if (state == RESPOND) begin
               for (int unsigned w = 0; w < WAYS; w++) begin
                  if (WAY_W'(w) == r_way)
                     age_q[r_set][w] <= '0;
                  else if (age_q[r_set][w] < age_q[r_set][r_way])
                     age_q[r_set][w] <= age_q[r_set][w] + 1'b1;
               end
            end
         end

         always_comb begin
            lru_way = '0;
            for (int unsigned w = 0; w < WAYS; w++)
               if (age_q[r_set][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
         end
      end else begin : g_direct
         assign lru_way = '0;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next          = state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_rdata    = '0;
      inv_busy      = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_req_addr  = '0;
      mem_wdata     = '0;
      unique case (state)
         IDLE: begin
            req_ready = reset && !inv_all;
            if (inv_all)        next = INVALIDATE;
            else if (req_valid) next = LOOKUP;
         end
         LOOKUP: begin
            if (hit)               next = RESPOND;
            else if (victim_dirty) next = WRITEBACK;
            else                   next = FILL_REQ;
         end
         WRITEBACK: begin
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_addr  = {tag_q[r_set][r_way], r_set, {OFF_W{1'b0}}};
            mem_wdata     = data_q[r_set][r_way];
            if (mem_req_ready) next = FILL_REQ;
         end
         FILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {r_tag, r_set, {OFF_W{1'b0}}};
            if (mem_req_ready) next = FILL_WAIT;
         end
         FILL_WAIT: if (mem_resp_valid) next = RESPOND;
         RESPOND: begin
            resp_valid = 1'b1;
            resp_rdata = r_write ? r_wdata : r_rdata;
            next       = IDLE;
         end
         INVALIDATE: begin
            inv_busy = 1'b1;
            if (inv_set == SET_W'(SETS - 1)) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_write <= 1'b0;
         r_hit   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_way   <= '0;
         inv_set <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               inv_set <= '0;
               if (!inv_all && req_valid) begin
                  r_write <= req_write;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
               end
            end
            LOOKUP: begin
               r_hit <= hit;
               r_way <= hit ? hit_way : victim;
               if (hit && !r_write) r_rdata <= data_q[r_set][hit_way][r_off];
            end
            FILL_WAIT:  if (mem_resp_valid) r_rdata <= mem_rdata[r_off*WORD_W +: WORD_W];
            INVALIDATE: inv_set <= inv_set + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned s = 0; s < SETS; s++)
            for (int unsigned w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
            end
      end else begin
         if (state == LOOKUP && hit && r_write) dirty_q[r_set][hit_way] <= 1'b1;
         if (state == FILL_WAIT && mem_resp_valid) begin
            valid_q[r_set][r_way] <= 1'b1;
            dirty_q[r_set][r_way] <= r_write;
         end
         // Dirty lines are dropped here on purpose: invalidate-all never writes back.
         if (state == INVALIDATE)
            for (int unsigned w = 0; w < WAYS; w++) begin
               valid_q[inv_set][w] <= 1'b0;
               dirty_q[inv_set][w] <= 1'b0;
            end
      end
   end

   always_ff @(posedge clock) begin
      if (state == LOOKUP && hit && r_write) data_q[r_set][hit_way][r_off] <= r_wdata;
      if (state == FILL_WAIT && mem_resp_valid) begin
         tag_q[r_set][r_way]  <= r_tag;
         data_q[r_set][r_way] <= fill_line;
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && inv_all) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == RESPOND) begin
         if (r_hit && hit_count != '1)    hit_count  <= hit_count + 1'b1;
         if (!r_hit && miss_count != '1)  miss_count <= miss_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache (4 sets, 2 ways, 4-word lines): directed hit/miss, eviction,
// invalidate and reset scenarios; build with CACHE_STATS_EN to also check the statistics counters.
module tb_assoc_cache;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [31:0]  req_addr = '0, req_wdata = '0;
   logic         resp_valid;
   logic [31:0]  resp_rdata;
   logic         inv_all = 1'b0, inv_busy;
   logic         mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_wdata;
   logic         mem_resp_valid = 1'b0;
   logic [127:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
   logic [31:0]  hit_count, miss_count;
`endif

   assoc_cache #(.SETS(4), .WAYS(2), .LINE_WORDS(4), .WORD_W(32), .ADDR_W(32)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .inv_all(inv_all), .inv_busy(inv_busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct { logic [31:0] data; bit lat; int acc; } exp_t;
   exp_t sbq[$];
   exp_t mon_e;
   int   pass_cnt = 0, total_cnt = 0, cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic fail_timeout(input string name);
      total_cnt++;
      $display("FAIL %s: timed out waiting for DUT, expected event", name);
   endtask

   // Lines returned by the next level: word k = (base << 8) | k, except line 0x10 word0.
   function automatic logic [127:0] mk_line(input logic [31:0] base);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = (base << 8) | 32'(k);
      if (base == 32'h10) l[31:0] = 32'hA5A5A5A5;
      return l;
   endfunction

   always @(negedge clock) begin
      if (reset && resp_valid) begin
         if (sbq.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_resp: got resp_rdata %h, expected no response", resp_rdata);
         end else begin
            mon_e = sbq.pop_front();
            check("resp_rdata", 128'(resp_rdata), 128'(mon_e.data));
            if (mon_e.lat) check("hit_latency", 128'(cyc + 1 - mon_e.acc), 128'(2));
         end
      end
   end

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input bit lat, input bit want_resp);
      exp_t e;
      bit   ok = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (req_ready) begin ok = 1'b1; break; end
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      if (!ok) fail_timeout("req_accept");
      else if (want_resp) begin
         e.data = exp; e.lat = lat; e.acc = cyc;
         sbq.push_back(e);
      end
   endtask

   task automatic mem_handshake(input string name, input logic wr, input logic [31:0] addr,
                                input logic [127:0] line, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (mem_req_valid) begin ok = 1'b1; break; end
      end
      if (!ok) begin fail_timeout({name, "_req"}); return; end
      check({name, "_write"}, 128'(mem_req_write), 128'(wr));
      check({name, "_addr"}, 128'(mem_req_addr), 128'(addr));
      if (wr) check({name, "_wdata"}, mem_wdata, line);
      @(posedge clock); #1 mem_req_ready = 1'b1;
      @(posedge clock); #1 mem_req_ready = 1'b0;
   endtask

   task automatic mem_serve(input string name, input logic wr, input logic [31:0] addr,
                            input logic [127:0] line);
      bit ok;
      mem_handshake(name, wr, addr, line, ok);
      if (ok && !wr) begin
         @(posedge clock); #1 mem_resp_valid = 1'b1; mem_rdata = line;
         @(posedge clock); #1 mem_resp_valid = 1'b0; mem_rdata = '0;
      end
   endtask

   task automatic drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (sbq.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin fail_timeout(name); sbq.delete(); end
      repeat (2) @(negedge clock);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 128'(req_ready), 128'(0));
      check({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
      check({tag, "_mem_req_valid"}, 128'(mem_req_valid), 128'(0));
      check({tag, "_inv_busy"}, 128'(inv_busy), 128'(0));
      check({tag, "_resp_rdata"}, 128'(resp_rdata), 128'(0));
      check({tag, "_mem_req_addr"}, 128'(mem_req_addr), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  busy;
      bit  ok;
      logic [127:0] wb_line;
      wb_line = {32'h1003, 32'h1002, 32'h1234, 32'hA5A5A5A5};

      // reset values, with a request pending so req_ready is genuinely gated
      req_valid = 1'b1;
      repeat (3) @(posedge clock);
      #1 check_reset_outputs("rst");
      req_valid = 1'b0;
      @(posedge clock); #1 reset = 1'b1;

      // cold miss then hit
      issue(1'b0, 32'h10, '0, 32'hA5A5A5A5, 1'b0, 1'b1);
      mem_serve("s1_fill", 1'b0, 32'h10, mk_line(32'h10));
      drain("s1_miss");
      issue(1'b0, 32'h10, '0, 32'hA5A5A5A5, 1'b1, 1'b1);
      drain("s1_hit");
`ifdef CACHE_STATS_EN
      check("hit_count", 128'(hit_count), 128'(1));
      check("miss_count", 128'(miss_count), 128'(1));
`endif

      // dirty LRU victim is written back before the fill
      issue(1'b1, 32'h11, 32'h1234, 32'h1234, 1'b1, 1'b1);
      drain("s2_write");
      issue(1'b0, 32'h20, '0, 32'h2000, 1'b0, 1'b1);
      mem_serve("s2_fill20", 1'b0, 32'h20, mk_line(32'h20));
      drain("s2_rd20");
      issue(1'b0, 32'h30, '0, 32'h3000, 1'b0, 1'b1);
      mem_serve("s2_wb", 1'b1, 32'h10, wb_line);
      mem_serve("s2_fill30", 1'b0, 32'h30, mk_line(32'h30));
      drain("s2_rd30");

      // 0x10,0x20,0x10,0x30: the 0x20 way is evicted, 0x10 survives
      issue(1'b0, 32'h10, '0, 32'hA5A5A5A5, 1'b0, 1'b1);
      mem_serve("s3_fill10", 1'b0, 32'h10, mk_line(32'h10));
      drain("s3_rd10a");
      issue(1'b0, 32'h20, '0, 32'h2000, 1'b0, 1'b1);
      mem_serve("s3_fill20", 1'b0, 32'h20, mk_line(32'h20));
      drain("s3_rd20");
      issue(1'b0, 32'h10, '0, 32'hA5A5A5A5, 1'b1, 1'b1);
      drain("s3_rd10b");
      issue(1'b0, 32'h30, '0, 32'h3000, 1'b0, 1'b1);
      mem_serve("s3_fill30", 1'b0, 32'h30, mk_line(32'h30));
      drain("s3_rd30");
      issue(1'b0, 32'h10, '0, 32'hA5A5A5A5, 1'b1, 1'b1);
      drain("s3_rd10c");
      issue(1'b0, 32'h20, '0, 32'h2000, 1'b0, 1'b1);
      mem_serve("s3_refill20", 1'b0, 32'h20, mk_line(32'h20));
      drain("s3_rd20b");

      // dirty 0x10 line, then invalidate-all racing a request
      issue(1'b1, 32'h11, 32'h77, 32'h77, 1'b1, 1'b1);
      drain("s4_write");
      @(posedge clock); #1;
      inv_all = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
      @(negedge clock);
      check("s4_req_ready", 128'(req_ready), 128'(0));
      @(posedge clock); #1;
      inv_all = 1'b0; req_valid = 1'b0;
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (inv_busy) busy++;
         else break;
      end
      check("s4_inv_cycles", 128'(busy), 128'(4));
      issue(1'b0, 32'h10, '0, 32'hA5A5A5A5, 1'b0, 1'b1);
      mem_serve("s4_fill10", 1'b0, 32'h10, mk_line(32'h10));
      drain("s4_rd10");

      // reset while waiting for fill data
      issue(1'b0, 32'h20, '0, '0, 1'b0, 1'b0);
      mem_handshake("s5_fill20", 1'b0, 32'h20, '0, ok);
      @(posedge clock); #1 reset = 1'b0;
      #1 check_reset_outputs("s5");
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1 mem_resp_valid = 1'b1; mem_rdata = mk_line(32'h20);
      @(posedge clock); #1 mem_resp_valid = 1'b0; mem_rdata = '0;
      @(negedge clock);
      check("s5_idle_ready", 128'(req_ready), 128'(1));
      issue(1'b0, 32'h10, '0, 32'hA5A5A5A5, 1'b0, 1'b1);
      mem_serve("s5_fill10", 1'b0, 32'h10, mk_line(32'h10));
      drain("s5_rd10");
      issue(1'b0, 32'h20, '0, 32'h2000, 1'b0, 1'b1);
      mem_serve("s5_refill20", 1'b0, 32'h20, mk_line(32'h20));
      drain("s5_rd20");

      repeat (3) @(posedge clock);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter SETS, default 64, number of sets; power of 2, at least 2.
REQ-002 Parameter WAYS, default 2, associativity; power of 2, 1..8.
REQ-003 Parameter LINE_WORDS, default 4, words per line; power of 2, at least 2.
REQ-004 Parameter WORD_W, default 32, word width in bits.
REQ-005 Parameter ADDR_W, default 32, word-address width.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 Ports SHALL be:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WORD_W  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WORD_W  read data, or echoed write data.
- inv_all  in  1  invalidate-all pulse.
- inv_busy  out  1  invalidation in progress.
- mem_req_valid  out  1  next-level request.
- mem_req_ready  in  1  next level accepts.
- mem_req_write  out  1  1 = line writeback, 0 = line fill.
- mem_req_addr  out  ADDR_W  line-aligned address (offset bits zero).
- mem_wdata  out  LINE_WORDS*WORD_W  writeback line.
- mem_resp_valid  in  1  fill data valid.
- mem_rdata  in  LINE_WORDS*WORD_W  fill line.

Function
REQ-008 The address split SHALL be:
- offset = low log2(LINE_WORDS) bits.
- set = next log2(SETS) bits.
- tag = remaining bits.
REQ-009 The FSM SHALL have states IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND, INVALIDATE.
REQ-010 req_ready SHALL be (state==IDLE && !inv_all); an accepted request is registered and goes to LOOKUP.
REQ-011 inv_all in IDLE SHALL win over a simultaneous req_valid and go to INVALIDATE; inv_all outside IDLE SHALL be ignored.
REQ-012 LOOKUP hit (valid && tag match) SHALL do the following, then go to RESPOND:
- read: capture the word.
- write: update the word and set dirty.
- hit latency: resp_valid exactly 2 cycles after the acceptance edge.
REQ-013 LOOKUP miss victim selection SHALL be: the lowest-index invalid way; otherwise the way with maximum LRU age.
REQ-014 On a miss, a valid dirty victim SHALL go to WRITEBACK; otherwise go to FILL_REQ.
REQ-015 WRITEBACK SHALL:
- hold mem_req_valid=1, mem_req_write=1, victim address and line until mem_req_ready;
- then go to FILL_REQ.
REQ-016 FILL_REQ SHALL hold mem_req_valid=1, mem_req_write=0, request line address until mem_req_ready, then go to FILL_WAIT.
REQ-017 FILL_WAIT SHALL wait for mem_resp_valid, then:
- install the line (valid=1, new tag, dirty=0);
- merge any write word and set dirty;
- go to RESPOND.
REQ-018 RESPOND SHALL:
- pulse resp_valid for one cycle;
- drive resp_rdata = read word, or req_wdata for writes;
- return to IDLE.
REQ-019 Each completed access SHALL update LRU: ways with age below the accessed way's age increment; the accessed way's age becomes 0; ages stay a permutation of 0..WAYS-1.
REQ-020 INVALIDATE SHALL:
- clear valid and dirty of one set per cycle, from set 0 to SETS-1;
- reset ages to the way index;
- hold inv_busy=1;
- take exactly SETS cycles, then go to IDLE.
REQ-021 Dirty data SHALL be discarded by INVALIDATE, with no writeback.
REQ-022 WAYS=1 SHALL degenerate to direct-mapped: no LRU storage, the victim is always way 0.

Reset
REQ-023 Reset assertion SHALL take effect immediately, at any state including mid-WRITEBACK or FILL, and return to IDLE.
REQ-024 Under reset:
- all valid and dirty bits are 0;
- ages are set to the way index;
- req_ready=0, resp_valid=0, mem_req_valid=0, inv_busy=0;
- resp_rdata=0, mem_req_addr=0.
REQ-025 An outstanding next-level transaction SHALL be abandoned on reset; mem_resp_valid SHALL be ignored outside FILL_WAIT.

Configuration
REQ-026 With CACHE_STATS_EN defined:
- outputs hit_count and miss_count (32 bits each) SHALL count completed hits and misses;
- both counters saturate at all-ones;
- both are cleared by reset and by INVALIDATE entry.
REQ-027 Without CACHE_STATS_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-028 The bench SHALL cover these directed scenarios, all with SETS=4, WAYS=2, LINE_WORDS=4:
- Read 0x10 cold: fill request for addr 0x10 with mem_req_write=0; return a line with word0=0xA5A5A5A5 -> resp_rdata=0xA5A5A5A5; a re-read of 0x10 then hits with resp_valid 2 cycles after acceptance.
- Write 0x11=0x1234, then reads of 0x20 and 0x30 (same set 0, evicting LRU way 0x10) -> writeback at addr 0x10 with word1=0x1234, followed by a fill of 0x30.
- Read 0x10, 0x20, 0x10, then 0x30 -> the victim is the 0x20 way; the next 0x10 read hits.
- inv_all and req_valid in the same IDLE cycle -> req_ready=0, inv_busy high exactly 4 cycles, then read 0x10 misses.
- Reset asserted during FILL_WAIT -> outputs go to reset values at once; a late mem_resp_valid is ignored; read 0x10 after reset misses.
- With CACHE_STATS_EN, the hit/miss sequence of scenario 1 -> hit_count=1, miss_count=1.
